mac_seq_ctrl: RTL
=================

# mac_seq_ctrl

Sequencer for the multiply-accumulate datapath: runs one dot product of SZN operand pairs per job. On `start` it clears the accumulator, then accepts SZN (a, x) pairs over a valid/ready stream and feeds each pair to the multiply-add stage. It presents the final sum on a held result handshake. It sits between the sample/coefficient source and whatever consumes filter or dot-product outputs.

## Interface
- SZin, 7: operand MSB index; operands are SZin+1 bits, unsigned.
- SZN, 3: pairs per job, ≥1.
- W (derived, localparam): 2*(SZin+1)+1, result width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request pulse; honoured only in IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- ina  in  SZin+1  operand a.
- inxni  in  SZin+1  operand x.
- busy  out  1  high in ACC and DONE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  W  dot-product result.
- ovf  out  1  overflow seen during this job.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: in_ready=0, out_valid=0. On start=1, go to ACC next cycle; accumulator cleared, pair counter cleared, ovf cleared.
- ACC: in_ready=1. Each accepted pair: acc <= acc + ina*inxni; counter+1. On the SZN-th accept, go to DONE. in_valid=0 stalls with no state change.
- DONE: in_ready=0, out_valid=1, res = final acc held stable. On out_ready=1, go to IDLE.
- start outside IDLE: ignored, no queueing.
- start and out_ready in the same DONE cycle: go to IDLE only; the start is dropped.
- Arithmetic: product is 2*(SZin+1) bits, zero-extended to W; sum is computed at W+1 bits. Carry out of bit W-1 sets ovf (sticky until the next start). Overflow handling is set by the Configuration section.
- res reflects acc at all times; it is meaningful only while out_valid=1.

## Timing
- Reset values: state=IDLE, acc=0, counter=0, in_ready=0, busy=0, out_valid=0, res=0, ovf=0.
- start at edge n: in_ready=1 from cycle n+1.
- Last pair accepted at edge m: out_valid=1 and final res from cycle m+1. Best-case job length is SZN+2 cycles from start to out_valid.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- rst mid-job: abort, all reset values next cycle; a partial sum is never output.

## Configuration
- MAC_SAT_EN defined: on overflow, acc saturates to 2^W−1 and stays there for the rest of the job; ovf=1.
- MAC_SAT_EN undefined: acc wraps modulo 2^W; ovf=1.

## Structure
- Shared package mac_pkg:
  - state enum (IDLE, ACC, DONE);
  - W formula;
  - counter width function $clog2(SZN+1).
- One sub-module, mac_stage: combinational product plus registered accumulate with clear, enable, saturation option and carry-out. The FSM and handshakes stay in mac_seq_ctrl.

## Test plan
- Basic job (SZin=3, SZN=5): start, then pairs (1,2),(2,3),(3,4),(4,5),(5,6) back-to-back → out_valid on the cycle after the 5th accept, res=70, ovf=0.
- Input stalls: same pairs with in_valid dropped for 2 cycles between every pair → res=70; counter does not advance while stalled.
- Overflow: five pairs of (15,15), total 1125 → without MAC_SAT_EN res=101, ovf=1; with MAC_SAT_EN res=511, ovf=1.
- Output backpressure: out_ready=0 for 4 cycles → out_valid and res=70 held stable; start pulses in DONE are ignored; out_ready=1 → IDLE next cycle.
- Reset mid-job: rst after 2 accepted pairs → all outputs at reset values. A new job with (1,1)×5 → res=5.
- Back-to-back jobs: start on the cycle after the result handshake → second job's res excludes the first job's sum.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC sequencer.
package mac_pkg;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   function automatic int res_w(input int szin);
      return 2 * (szin + 1) + 1;
   endfunction

   function automatic int cnt_w(input int szn);
      return $clog2(szn + 1);
   endfunction

endpackage

// File: rtl/mac_stage.sv
// Multiply-add stage: product plus registered accumulator.
// MAC_SAT_EN selects saturating accumulate; default wraps.
module mac_stage
   import mac_pkg::*;
#(
   parameter int SZin = 7,
   parameter int W    = res_w(SZin)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [SZin:0] a,
   input  logic [SZin:0] x,
   output logic [W-1:0]  acc,
   output logic          cout
);

   localparam int PW = 2 * (SZin + 1);

   logic [PW-1:0] prod;
   logic [W:0]    sum;

   always_comb begin
      prod = a * x;
      sum  = {1'b0, acc} + {{(W + 1 - PW){1'b0}}, prod};
      cout = sum[W];
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
`ifdef MAC_SAT_EN
         acc <= cout ? {W{1'b1}} : sum[W-1:0];
`else
         acc <= sum[W-1:0];
`endif
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: one job of SZN pairs per start pulse.
// Overflow policy comes from mac_stage (MAC_SAT_EN).
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int SZin = 7,
   parameter int SZN  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SZin:0]            ina,
   input  logic [SZin:0]            inxni,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [res_w(SZin)-1:0]   res,
   output logic                     ovf
);

   localparam int W  = res_w(SZin);
   localparam int CW = cnt_w(SZN);
   localparam logic [CW-1:0] LAST = CW'(SZN - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          clr;
   logic          en;
   logic          cout;

   assign clr = (state == IDLE) && start;
   assign en  = (state == ACC) && in_valid;

   mac_stage #(.SZin(SZin), .W(W)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (en),
      .a    (ina),
      .x    (inxni),
      .acc  (res),
      .cout (cout)
   );

   // Handshake outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACC;
                  cnt      <= '0;
                  ovf      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACC: begin
               if (in_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cout) ovf <= 1'b1;
                  if (cnt == LAST) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
